bcd_digit_scanner: RTL and testbench
====================================

# bcd_digit_scanner

Time-multiplexed seven-segment display driver that consumes the 4-bit BCD outputs of the decade counter chain. It snapshots `DIGITS` packed BCD digits once per frame and scans them one digit at a time onto shared active-low segment lines. It also applies leading-zero blanking and shows a dash for non-BCD codes (10–15), including the value 10 the upstream counter can emit. It sits between the counter chain and the board display pins.

## Interface
- `DIGITS`, 4: number of display digits (1–8); digit 0 is least significant.
- `DIV`, 1000: clock cycles per digit slot (≥2).
- `clk`  in  1: clock.
- `rst`  in  1: synchronous, active-high reset.
- `en`  in  1: scan enable; 0 freezes the scan and darkens the display.
- `blank_lz`  in  1: 1 enables leading-zero blanking.
- `bcd`  in  4*DIGITS: packed digits; `bcd[4i+3:4i]` is digit i.
- `an`  out  DIGITS: active-low digit enables; `an[i]`=0 lights digit i.
- `seg`  out  7: active-low segments {g,f,e,d,c,b,a}.
- `frame_tick`  out  1: one-cycle pulse, registered, asserted the cycle after a snapshot load.

## Operation
- State:
  - `div_cnt`: 0..DIV-1, clog2(DIV) bits.
  - `idx`: 0..DIGITS-1, clog2(DIGITS) bits, minimum 1 bit.
  - `snap`: 4*DIGITS bits.
  - output registers `an`, `seg`, `frame_tick`.
- Reset (`rst`=1 at a clock edge):
  - `div_cnt`=0, `idx`=0, `snap`=0.
  - `an`=all 1, `seg`=7'h7F, `frame_tick`=0.
- `en`=1, `div_cnt` < DIV-1: `div_cnt`++.
- `en`=1, `div_cnt`==DIV-1: `div_cnt`→0; `idx`→`idx`+1, wrapping DIGITS-1→0.
- Snapshot: when `en`=1, `div_cnt`==0 and `idx`==0, `snap`←`bcd`. `bcd` is sampled only then, so there is no tearing within a frame.
- Blanking slot: any cycle with `div_cnt`==0 drives all digits off (anti-ghosting).
- Decode of digit `snap[idx]`:
  - 0–9: standard patterns, e.g. 0=7'b1000000, 1=7'b1111001, 7=7'b1111000, 8=7'b0000000.
  - 10–15: dash, 7'b0111111 (g only).
- Leading-zero blanking: with `blank_lz`=1, digit i>0 is blanked (`an[i]`=1) when `snap` digits i..DIGITS-1 are all 0. Digit 0 is never blanked. Codes 10–15 count as non-zero.
- `en`=0: `div_cnt`, `idx` and `snap` hold; outputs go dark (`an`=all 1, `seg`=7'h7F, `frame_tick`=0). When `en` returns to 1, scanning resumes from the held state.
- `rst` mid-frame overrides everything; the next frame restarts at `idx`=0 with a fresh snapshot.

## Timing
- Outputs are fully registered. `an`/`seg` at cycle t+1 are a function of `div_cnt`, `idx`, `snap`, `en` and `blank_lz` at cycle t.
- Frame length is DIGITS*DIV cycles; each digit is lit for DIV-1 cycles per frame.
- Snapshot latency: a change on `bcd` appears at most DIGITS*DIV+2 cycles later.
- First lit output after reset release with `en`=1: cycle 3. Cycle 1 has `div_cnt`=0 (snapshot taken, output dark); cycle 2 shows the registered blank; cycle 3 drives digit 0 from the new `snap`.
- `frame_tick`=1 in the cycle immediately after each snapshot load.

## Structure
- Package `bcd_disp_pkg` holds:
  - segment constants `SEG_BLANK`, `SEG_DASH`, `SEG_DIGIT[0:9]`;
  - the helper `clog2_min1`.
- Sub-module `bcd_to_7seg`: combinational, 4-bit code in, 7-bit active-low pattern out, dash for 10–15.
- Top level: divider, index counter, snapshot register, leading-zero mask and output registers.

## Test plan
- All scenarios use DIGITS=4, DIV=4 (16-cycle frame).
- Reset: hold `rst` 3 cycles with `bcd`=16'h1234, `en`=1 → `an`=4'hF, `seg`=7'h7F, `frame_tick`=0 throughout; after release, `frame_tick` pulses in cycle 2 and digit 0 shows 7'b0011001 ("4") in cycles 3–5.
- Scan order: `bcd`=16'h1234 steady → across one frame, `an` sequence is E,D,B,7, each held 3 cycles, separated by a one-cycle F; `seg` follows 4,3,2,1.
- Leading-zero blanking: `bcd`=16'h0070, `blank_lz`=1 → digits 3 and 2 stay dark; digit 1 shows 7'b1111000; digit 0 shows 7'b1000000. With `blank_lz`=0, all four digits are lit. With `bcd`=16'h0000, only digit 0 lights.
- Invalid code: `bcd`=16'h00A5, `blank_lz`=1 → digit 1 shows 7'b0111111 and is not blanked; digit 0 shows "5" (7'b0010010).
- Snapshot stability: change `bcd` from 16'h1111 to 16'h2222 mid-frame → the remaining digits of that frame still show "1"; the next frame shows "2" after `frame_tick`.
- Enable/reset mid-operation:
  - Drop `en` for 5 cycles during digit 2 → outputs dark, then digit 2 resumes with its remaining slot cycles.
  - Assert `rst` during digit 3 → outputs dark next cycle, and scanning restarts at digit 0.

Source files
------------

// File: rtl/bcd_digit_scanner_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment display driver.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package bcd_disp_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  // Counter width that never collapses to zero bits.
  function automatic int clog2_min1(input int value);
    return (value <= 2) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/bcd_digit_scanner_if.sv
// Bundle of the BCD input bus, control inputs and display pin outputs.
// The master drives digits/controls; the slave (scanner) drives the pins.
interface bcd_digit_scanner_if #(
  parameter int DIGITS = 4
);
  logic                  en;
  logic                  blank_lz;
  logic [4*DIGITS-1:0]   bcd;
  logic [DIGITS-1:0]     an;
  logic [6:0]            seg;
  logic                  frame_tick;

  modport master (
    output en, blank_lz, bcd,
    input  an, seg, frame_tick
  );

  modport slave (
    input  en, blank_lz, bcd,
    output an, seg, frame_tick
  );
endinterface

// File: rtl/bcd_digit_scanner_bcd_to_7seg.sv
// Combinational BCD to active-low seven-segment decoder.
// Non-BCD codes (10-15) render as a dash so upstream overflow is visible.
module bcd_to_7seg
  import bcd_disp_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_DASH;
    case (code_i)
      4'd0: seg_o = SEG_DIGIT[0];
      4'd1: seg_o = SEG_DIGIT[1];
      4'd2: seg_o = SEG_DIGIT[2];
      4'd3: seg_o = SEG_DIGIT[3];
      4'd4: seg_o = SEG_DIGIT[4];
      4'd5: seg_o = SEG_DIGIT[5];
      4'd6: seg_o = SEG_DIGIT[6];
      4'd7: seg_o = SEG_DIGIT[7];
      4'd8: seg_o = SEG_DIGIT[8];
      4'd9: seg_o = SEG_DIGIT[9];
      default: seg_o = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_digit_scanner.sv
// Time-multiplexed display scanner: per-frame BCD snapshot, digit divider,
// leading-zero blanking and fully registered active-low an/seg outputs.
module bcd_digit_scanner #(
  parameter int DIGITS = 4,
  parameter int DIV    = 1000
) (
  input  logic             clk,
  input  logic             rst,
  bcd_digit_scanner_if.slave bus
);
  import bcd_disp_pkg::*;

  localparam int DW = clog2_min1(DIV);
  localparam int IW = clog2_min1(DIGITS);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [DW-1:0]         div_cnt_q, div_cnt_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   snap_q, snap_d;
  logic [DIGITS-1:0]     an_q, an_d;
  logic [6:0]            seg_q, seg_d;
  logic                  frame_tick_q, frame_tick_d;

  logic [3:0]            cur_code;
  logic [6:0]            cur_seg;
  logic [DIGITS-1:0]     lz_blank;

  // A digit is a leading zero when it and every more significant digit are 0.
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_lz
      if (gi == 0) begin : g_lsd
        assign lz_blank[gi] = 1'b0;
      end else begin : g_upper
        assign lz_blank[gi] = bus.blank_lz && ((snap_q >> (4 * gi)) == '0);
      end
    end
  endgenerate

  assign cur_code = snap_q[idx_q * 4 +: 4];

  bcd_to_7seg u_dec (
    .code_i (cur_code),
    .seg_o  (cur_seg)
  );

  always_comb begin
    div_cnt_d    = div_cnt_q;
    idx_d        = idx_q;
    snap_d       = snap_q;
    an_d         = '1;
    seg_d        = SEG_BLANK;
    frame_tick_d = 1'b0;
    if (bus.en) begin
      if (div_cnt_q == DIV_LAST) begin
        div_cnt_d = '0;
        idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
      if (div_cnt_q == '0 && idx_q == '0) begin
        snap_d       = bus.bcd;
        frame_tick_d = 1'b1;
      end
      // Slot cycle 0 stays dark so the previous digit never ghosts.
      if (div_cnt_q != '0 && !lz_blank[idx_q]) begin
        an_d[idx_q] = 1'b0;
        seg_d       = cur_seg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q    <= '0;
      idx_q        <= '0;
      snap_q       <= '0;
      an_q         <= '1;
      seg_q        <= SEG_BLANK;
      frame_tick_q <= 1'b0;
    end else begin
      div_cnt_q    <= div_cnt_d;
      idx_q        <= idx_d;
      snap_q       <= snap_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_bcd_digit_scanner.sv
// Directed bench for bcd_digit_scanner (DIGITS=4, DIV=4) with a frame-position
// reference model compared every cycle plus hand-computed literal checks.
module tb_bcd_digit_scanner;
  localparam int DIGITS = 4;
  localparam int DIV    = 4;
  localparam int FRAME  = DIGITS * DIV;

  logic clk = 1'b0;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  bcd_digit_scanner_if #(.DIGITS(DIGITS)) bus ();

  bcd_digit_scanner #(.DIGITS(DIGITS), .DIV(DIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] seg_ref(input logic [3:0] v);
    case (v)
      4'd0: return 7'h40;
      4'd1: return 7'h79;
      4'd2: return 7'h24;
      4'd3: return 7'h30;
      4'd4: return 7'h19;
      4'd5: return 7'h12;
      4'd6: return 7'h02;
      4'd7: return 7'h78;
      4'd8: return 7'h00;
      4'd9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  // Model: position within the frame counts enabled cycles; the digit shown is
  // pos/DIV and the first cycle of each slot is dark.
  int         m_pos = 0;
  logic [3:0] m_snap [DIGITS];
  logic [DIGITS-1:0] exp_an  = '1;
  logic [6:0]        exp_seg = 7'h7F;
  logic              exp_ft  = 1'b0;

  always @(posedge clk) begin
    automatic int d = m_pos / DIV;
    automatic int ph = m_pos % DIV;
    automatic logic nz = 1'b0;
    automatic logic [DIGITS-1:0] a = '1;
    automatic logic [6:0] s = 7'h7F;
    if (rst) begin
      m_pos   <= 0;
      for (int j = 0; j < DIGITS; j++) m_snap[j] <= 4'd0;
      exp_an  <= '1;
      exp_seg <= 7'h7F;
      exp_ft  <= 1'b0;
    end else if (!bus.en) begin
      exp_an  <= '1;
      exp_seg <= 7'h7F;
      exp_ft  <= 1'b0;
    end else begin
      for (int j = 0; j < DIGITS; j++) if (j >= d && m_snap[j] != 4'd0) nz = 1'b1;
      if (ph != 0 && !(bus.blank_lz && d > 0 && !nz)) begin
        a[d] = 1'b0;
        s = seg_ref(m_snap[d]);
      end
      exp_an  <= a;
      exp_seg <= s;
      exp_ft  <= (m_pos == 0);
      if (m_pos == 0)
        for (int j = 0; j < DIGITS; j++) m_snap[j] <= bus.bcd[4*j +: 4];
      m_pos <= (m_pos + 1) % FRAME;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: sample #1 after the edge, compare against the model, log the cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    check("model_an", 32'(bus.an), 32'(exp_an));
    check("model_seg", 32'(bus.seg), 32'(exp_seg));
    check("model_ft", 32'(bus.frame_tick), 32'(exp_ft));
    $display("t=%0t rst=%0b en=%0b lz=%0b bcd=%04h an=%h seg=%02h ft=%0b",
             $time, rst, bus.en, bus.blank_lz, bus.bcd, bus.an, bus.seg, bus.frame_tick);
  endtask

  task automatic wait_ft(output bit found);
    found = 1'b0;
    for (int k = 0; k < 3 * FRAME && !found; k++) begin
      tick();
      if (bus.frame_tick) found = 1'b1;
    end
    if (!found) check("frame_tick_timeout", 32'd0, 32'd1);
  endtask

  // Flush until the new value is snapshotted, then tally one full frame.
  task automatic measure(input logic [15:0] v, input logic lz,
                         output int lit [DIGITS], output logic [6:0] sg [DIGITS]);
    bus.bcd = v;
    bus.blank_lz = lz;
    for (int k = 0; k < FRAME + 4; k++) tick();
    for (int i = 0; i < DIGITS; i++) begin lit[i] = 0; sg[i] = 7'h7F; end
    for (int k = 0; k < FRAME; k++) begin
      tick();
      for (int i = 0; i < DIGITS; i++)
        if (bus.an == ~(DIGITS'(1) << i)) begin lit[i]++; sg[i] = bus.seg; end
    end
  endtask

  logic [3:0] scan_an  [15] = '{4'hE,4'hE,4'hE,4'hF,4'hD,4'hD,4'hD,4'hF,
                                4'hB,4'hB,4'hB,4'hF,4'h7,4'h7,4'h7};
  logic [6:0] scan_seg [15] = '{7'h19,7'h19,7'h19,7'h7F,7'h30,7'h30,7'h30,7'h7F,
                                7'h24,7'h24,7'h24,7'h7F,7'h79,7'h79,7'h79};

  initial begin
    int lit [DIGITS];
    logic [6:0] sg [DIGITS];
    bit found;
    int cnt;

    rst = 1'b1;
    bus.en = 1'b1;
    bus.blank_lz = 1'b0;
    bus.bcd = 16'h1234;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("reset_an", 32'(bus.an), 32'hF);
      check("reset_seg", 32'(bus.seg), 32'h7F);
      check("reset_ft", 32'(bus.frame_tick), 32'h0);
    end
    rst = 1'b0;
    tick();
    check("first_ft_cycle2", 32'(bus.frame_tick), 32'h1);
    for (int c = 0; c < 15; c++) begin
      tick();
      check("scan_an", 32'(bus.an), 32'(scan_an[c]));
      check("scan_seg", 32'(bus.seg), 32'(scan_seg[c]));
    end
    tick();
    check("second_ft", 32'(bus.frame_tick), 32'h1);

    measure(16'h0070, 1'b1, lit, sg);
    check("lz_d3_dark", 32'(lit[3]), 32'd0);
    check("lz_d2_dark", 32'(lit[2]), 32'd0);
    check("lz_d1_lit", 32'(lit[1]), 32'd3);
    check("lz_d1_seg", 32'(sg[1]), 32'h78);
    check("lz_d0_seg", 32'(sg[0]), 32'h40);

    measure(16'h0070, 1'b0, lit, sg);
    check("nolz_d3_lit", 32'(lit[3]), 32'd3);
    check("nolz_d2_lit", 32'(lit[2]), 32'd3);
    check("nolz_d3_seg", 32'(sg[3]), 32'h40);

    measure(16'h0000, 1'b1, lit, sg);
    check("zero_d0_lit", 32'(lit[0]), 32'd3);
    check("zero_upper_dark", 32'(lit[1] + lit[2] + lit[3]), 32'd0);

    measure(16'h00A5, 1'b1, lit, sg);
    check("dash_d1_lit", 32'(lit[1]), 32'd3);
    check("dash_d1_seg", 32'(sg[1]), 32'h3F);
    check("dash_d0_seg", 32'(sg[0]), 32'h12);

    // Snapshot stability: change bcd while digit 1 is on screen.
    bus.blank_lz = 1'b0;
    bus.bcd = 16'h1111;
    for (int k = 0; k < FRAME + 4; k++) tick();
    wait_ft(found);
    for (int k = 0; k < 5; k++) tick();
    bus.bcd = 16'h2222;
    found = 1'b0;
    for (int k = 0; k < 2 * FRAME && !found; k++) begin
      tick();
      if (bus.frame_tick) found = 1'b1;
      else if (bus.an != 4'hF) check("stale_seg_is_1", 32'(bus.seg), 32'h79);
    end
    if (!found) check("frame_tick_timeout", 32'd0, 32'd1);
    tick();
    check("new_frame_an", 32'(bus.an), 32'hE);
    check("new_frame_seg", 32'(bus.seg), 32'h24);

    // Enable drop during digit 2.
    wait_ft(found);
    for (int k = 0; k < 9; k++) tick();
    check("pre_drop_an", 32'(bus.an), 32'hB);
    bus.en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("en_off_an", 32'(bus.an), 32'hF);
    end
    bus.en = 1'b1;
    cnt = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (bus.an == 4'hB) cnt++;
    end
    check("resume_d2_cycles", 32'(cnt), 32'd2);

    // Reset during digit 3.
    wait_ft(found);
    for (int k = 0; k < 13; k++) tick();
    check("pre_rst_an", 32'(bus.an), 32'h7);
    rst = 1'b1;
    tick();
    check("rst_mid_an", 32'(bus.an), 32'hF);
    tick();
    rst = 1'b0;
    tick();
    check("restart_ft", 32'(bus.frame_tick), 32'h1);
    tick();
    check("restart_an", 32'(bus.an), 32'hE);
    check("restart_seg", 32'(bus.seg), 32'h24);
    for (int k = 0; k < FRAME; k++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
